// File: rtl/mips_cpu_multdiv.sv
// rtl/mips_cpu_multdiv.sv - iterative MIPS multiply/divide unit owning HI/LO (optional MADD/MADDU via MULTDIV_MADD_EN)
module mips_cpu_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // acc_hi: product upper half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    // opnd: multiplicand or divisor magnitude
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_a;
    logic             neg_b;
    logic             div0;
`ifdef MULTDIV_MADD_EN
    logic             is_madd;
`endif

    logic             op_mul;
    logic             op_div;
    logic             op_mt;
    logic             op_madd;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Decode the requested op and form operand magnitudes for the sign-magnitude datapath
    always_comb begin
        op_mul    = (op == 3'b000) || (op == 3'b001);
        op_div    = (op[2:1] == 2'b01);
        op_mt     = (op[2:1] == 2'b10);
        op_madd   = 1'b0;
`ifdef MULTDIV_MADD_EN
        op_madd   = (op[2:1] == 2'b11);
`endif
        op_signed = ~op[0];
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;

    // One shift-add multiply step and one restoring divide step, selected by is_div
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // When div_ge holds the true difference is below the divisor, so W bits suffice
        div_sub   = div_shift[WIDTH-1:0] - opnd;
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
`ifdef MULTDIV_MADD_EN
    logic [2*WIDTH-1:0] madd_sum;
`endif

    // Sign correction applied in FINISH: product/quotient follow sign(a)^sign(b), remainder follows a
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = (neg_a ^ neg_b) ? -acc_lo : acc_lo;
        rem_fix  = neg_a ? -acc_hi : acc_hi;
`ifdef MULTDIV_MADD_EN
        madd_sum = {hi, lo} + prod_fix;
`endif
    end

    // Control FSM and datapath registers; HI/LO are written only on MTHI/MTLO or in FINISH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            div0   <= 1'b0;
`ifdef MULTDIV_MADD_EN
            is_madd <= 1'b0;
`endif
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (op_mul || op_div || op_madd) begin
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                            neg_a  <= a_neg;
                            neg_b  <= b_neg;
                            is_div <= op_div;
                            div0   <= (b == '0);
`ifdef MULTDIV_MADD_EN
                            is_madd <= op_madd;
`endif
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end else if (op_mt) begin
                            if (op[0]) begin
                                lo <= a;
                            end else begin
                                hi <= a;
                            end
                            done <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (is_div) begin
                        lo <= div0 ? {WIDTH{1'b1}} : quo_fix;
                        hi <= rem_fix;
`ifdef MULTDIV_MADD_EN
                    end else if (is_madd) begin
                        {hi, lo} <= madd_sum;
`endif
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// tb/tb_mips_cpu_multdiv.sv - scoreboard bench for mips_cpu_multdiv
module tb_mips_cpu_multdiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] sb[$];
    logic [63:0] model_hilo = '0;

    always #5 clk = ~clk;

    mips_cpu_multdiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written with native integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] cur);
        longint      sx, sy, sp;
        logic [63:0] ux, uy;
        int          ix, iy, iq, ir;
        logic [31:0] uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sp = sx * sy;
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            3'd0: return 64'(sp);
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ix = $signed(x);
                iy = $signed(y);
                iq = ix / iy;
                ir = ix % iy;
                return {32'(ir), 32'(iq)};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = x / y;
                ur = x % y;
                return {ur, uq};
            end
            3'd4: return {x, cur[31:0]};
            3'd5: return {cur[63:32], x};
`ifdef MULTDIV_MADD_EN
            3'd6: return cur + 64'(sp);
            3'd7: return cur + ux * uy;
`endif
            default: return cur;
        endcase
    endfunction

    // Drive one start pulse; the expected result joins the scoreboard when pushed
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) begin
            model_hilo = model(o, x, y, model_hilo);
            sb.push_back(model_hilo);
        end
        step();
        start = 1'b0;
    endtask

    // Wait (bounded) for done, checking busy each cycle and scrambling operands, then score
    task automatic finish_op(input string tag, input int exp_lat);
        int n;
        logic [63:0] exp;
        n = 0;
        while (!done && n < 60) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            a = $urandom;
            b = $urandom;
            step();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_sb_pending"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
            chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        step();

        // Load HI/LO, then reset in the middle of a MULTU
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        finish_op("mthi", 0);
        issue(3'd5, 32'hCAFE_F00D, 32'd0, 1'b1);
        finish_op("mtlo", 0);
        issue(3'd1, 32'h0000_1234, 32'h0000_5678, 1'b1);
        for (int i = 0; i < 10; i++) step();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        sb.delete();
        model_hilo = '0;
        step();
        reset = 1'b0;
        step();

        // MULTU max x max with full latency/busy window check
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        finish_op("multu_max", 33);
        chk("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_max_lo_const", 64'(lo), 64'h0000_0001);
        chk("multu_max_done", 64'(done), 64'd1);
        step();
        chk("multu_max_done_fall", 64'(done), 64'd0);
        chk("multu_max_busy_after", 64'(busy), 64'd0);

        issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
        finish_op("mult_neg", 33);
        chk("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        finish_op("div_neg", 33);
        chk("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
        chk("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);

        issue(3'd3, 32'd1234, 32'd0, 1'b1);
        finish_op("divu_zero", 33);
        chk("divu_zero_lo_const", 64'(lo), 64'hFFFF_FFFF);
        chk("divu_zero_hi_const", 64'(hi), 64'd1234);

        issue(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b1);
        finish_op("div_zero_signed", 33);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        finish_op("div_ovf", 33);
        chk("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi_const", 64'(hi), 64'd0);

        issue(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);
        finish_op("div_pos_neg", 33);
        issue(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
        finish_op("div_neg_neg", 33);
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        finish_op("mult_minmin", 33);

`ifdef MULTDIV_MADD_EN
        issue(3'd6, 32'hFFFF_FFFE, 32'd3, 1'b1);
        finish_op("madd", 33);
        issue(3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1);
        finish_op("maddu", 33);
`else
        issue(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0);
        chk("rsv6_busy", 64'(busy), 64'd0);
        chk("rsv6_done", 64'(done), 64'd0);
        issue(3'd7, 32'h3333_3333, 32'h4444_4444, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("rsv7_busy", 64'(busy), 64'd0);
            chk("rsv7_done", 64'(done), 64'd0);
            step();
        end
        chk("rsv_hilo", {hi, lo}, model_hilo);
`endif

        // MTLO then back-to-back MULTU in the done cycle; a start while busy is ignored
        issue(3'd5, 32'h1234_5678, 32'd0, 1'b1);
        chk("b2b_mtlo_done", 64'(done), 64'd1);
        chk("b2b_mtlo_lo", 64'(lo), 64'h1234_5678);
        finish_op("b2b_mtlo", 0);
        issue(3'd1, 32'd3, 32'd5, 1'b1);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_done_fall", 64'(done), 64'd0);
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        finish_op("b2b_multu", 32);
        chk("b2b_hi_const", 64'(hi), 64'd0);
        chk("b2b_lo_const", 64'(lo), 64'd15);
        step();
        for (int i = 0; i < 40; i++) begin
            if (done) chk("b2b_no_extra_done", 64'(done), 64'd0);
            step();
        end
        chk("b2b_hilo_held", {hi, lo}, model_hilo);

        // Random signed/unsigned multiply and divide
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (rb[31] && i % 3 == 0) rb = -rb;
            issue(ro, ra, rb, 1'b1);
            finish_op("rand", 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
